// File: rtl/xnor_serial_cmp_ctrl.sv
// xnor_serial_cmp_ctrl: bit-serial equality comparator that reuses one XNOR cell
// across all bit positions and reports the match count with a start/busy/done handshake.
module xnor_serial_cmp_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [CNT_W-1:0] match_cnt
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CNT_W-1:0] idx_q, idx_d, acc_q, acc_d, cnt_q, cnt_d, sum;
    logic             eq_q, eq_d, accept, run, last;
    always_comb begin
        accept  = (state_q == IDLE) && start;
        run     = (state_q == RUN);
        last    = run && (idx_q == CNT_W'(WIDTH - 1));
        sum     = acc_q + CNT_W'(~(sa_q[0] ^ sb_q[0]));
        state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
        sa_d    = accept ? a_in : run ? sa_q >> 1 : sa_q;
        sb_d    = accept ? b_in : run ? sb_q >> 1 : sb_q;
        idx_d   = accept ? '0 : run ? idx_q + CNT_W'(1) : idx_q;
        acc_d   = accept ? '0 : run ? sum : acc_q;
        // Result registers load on the final RUN bit so they are valid in the DONE cycle.
        cnt_d   = last ? sum : cnt_q;
        eq_d    = last ? (sum == CNT_W'(WIDTH)) : eq_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
        end
    end
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign equal     = eq_q;
    assign match_cnt = cnt_q;
endmodule

// File: tb/tb_xnor_serial_cmp_ctrl.sv
// tb_xnor_serial_cmp_ctrl: randomized and directed checks of the serial comparator
// against a countdown/popcount reference model.
module tb_xnor_serial_cmp_ctrl;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0]  a_in = '0, b_in = '0;
    logic          busy, done, equal;
    logic [CW-1:0] match_cnt;
    int errors = 0, checks = 0, done_seen = 0;
    int m_left = 0, m_res = 0, m_match = 0, m_eq = 0;
    bit chk_en = 1'b0;

    xnor_serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .equal(equal), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start arms a countdown of W+1 cycles; the last one is the done cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_match = 0; m_eq = 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_left = W + 1;
                m_res  = $countones(~(a_in ^ b_in));
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_match = m_res;
                m_eq    = (m_res == W);
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) if (chk_en) begin
        check("busy", int'(busy), int'(m_left > 0));
        check("done", int'(done), int'(m_left == 1));
        check("match_cnt", int'(match_cnt), m_match);
        check("equal", int'(equal), m_eq);
        if (done) done_seen++;
    end

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk); start = 1'b1; a_in = a; b_in = b;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = n; break; end
        end
        if (lat == 0) begin
            errors++;
            $display("FAIL timeout: got no done expected done within 30 cycles");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int lat, d0;
        idle(2);
        check("reset busy", int'(busy), 0);
        check("reset cnt", int'(match_cnt), 0);
        rst_n = 1'b1;
        idle(2);
        run(8'hA5, 8'hA5, lat);
        check("t1 latency", lat, W + 1);
        check("t1 cnt", int'(match_cnt), 8);
        check("t1 equal", int'(equal), 1);
        idle(2);
        run(8'hFF, 8'h00, lat);
        check("t2 cnt", int'(match_cnt), 0);
        check("t2 equal", int'(equal), 0);
        idle(5);
        check("t2 held cnt", int'(match_cnt), 0);
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a_in = 8'hF0; b_in = 8'hF1;
        @(negedge clk); start = 1'b0;
        idle(2);
        start = 1'b1; a_in = 8'h00; b_in = 8'h00;
        @(negedge clk); start = 1'b0;
        idle(20);
        check("t3 dones", done_seen - d0, 1);
        check("t3 cnt", int'(match_cnt), 7);
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a_in = 8'h0F; b_in = 8'h3C;
        idle(40);
        start = 1'b0;
        idle(12);
        check("t4 dones", done_seen - d0, 4);
        check("t4 cnt", int'(match_cnt), 4);
        d0 = done_seen;
        @(negedge clk); start = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
        @(negedge clk); start = 1'b0;
        idle(3);
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("t5 busy", int'(busy), 0);
        idle(15);
        check("t5 dones", done_seen - d0, 0);
        check("t5 cnt", int'(match_cnt), 0);
        run(8'hFF, 8'hFF, lat);
        check("t5 rerun cnt", int'(match_cnt), 8);
        idle(2);
        rst_n = 1'b0; start = 1'b1; a_in = 8'h12; b_in = 8'h12;
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        check("t6 busy", int'(busy), 0);
        idle(3);
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            a_in  = W'($urandom);
            b_in  = ($urandom_range(0, 3) == 0) ? a_in : a_in ^ W'(1 << $urandom_range(0, W - 1)) ^ W'($urandom_range(0, 1) ? $urandom : 0);
            rst_n = ($urandom_range(0, 60) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0;
        idle(12);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xnor_serial_cmp_ctrl.md
Name: xnor_serial_cmp_ctrl

Overview:
Bit-serial equality comparator controller. A single 1-bit XNOR cell is shared across all bit positions of two WIDTH-bit operands, and the block sequences that cell over them one bit per clock. It accumulates the number of matching bit positions and reports word equality with a start/busy/done handshake. It is the sequencing layer that turns the team's 1-bit XNOR gate into a word comparator, where area matters more than latency.

Parameters:
WIDTH, 8, operand width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), width of the match counter (derived; do not override).

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  synchronous active-low reset
start  input  1  request a compare; sampled only in IDLE
a_in  input  WIDTH  operand A; captured on an accepted start
b_in  input  WIDTH  operand B; captured on an accepted start
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle pulse when the result is valid
equal  output  1  1 when all WIDTH bits matched; held until the next done
match_cnt  output  CNT_W  count of bit positions where A XNOR B = 1; held until the next done

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE.
- busy=0, done=0, equal=0, match_cnt=0.
- Shift registers, bit index and accumulator cleared.
- Reset has priority over every other event.

FSM states: IDLE, RUN, DONE.

IDLE:
- start=1 at an edge: latch a_in/b_in into shift registers sa/sb, acc=0, idx=0, go to RUN.
- start=0: stay in IDLE.

RUN:
- Each cycle: acc <= acc + (sa[0] XNOR sb[0]); sa, sb shift right by 1; idx <= idx+1.
- When idx==WIDTH-1, that cycle's bit is included and the next state is DONE.
- RUN lasts exactly WIDTH cycles.

DONE (one cycle):
- done=1.
- match_cnt and equal, registered on entry to DONE: match_cnt=acc, equal=(acc==WIDTH).
- Next state is IDLE unconditionally.

Timing and handshake:
- Latency: start accepted at edge T → done high in cycle T+WIDTH+1.
- busy is high from cycle T+1 through the DONE cycle.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored and is not queued. Captured operands are unaffected.
- a_in/b_in changes after acceptance have no effect on the running compare.
- match_cnt/equal change only in the DONE cycle. They hold their previous values through IDLE and RUN.
- Arithmetic: acc is CNT_W bits unsigned and must hold WIDTH without overflow.
- Reset mid-RUN: abort immediately. No done pulse; outputs cleared to 0.
- Simultaneous rst_n=0 and start=1: reset wins, start is dropped.

Test Plan:
1. WIDTH=8. start=1 for 1 cycle at T with a_in=b_in=8'hA5 → busy=1 for T+1..T+9; done=1 only at T+9; match_cnt=8, equal=1.
2. a_in=8'hFF, b_in=8'h00 → at done: match_cnt=0, equal=0. Values held unchanged through 5 idle cycles afterward.
3. a_in=8'hF0, b_in=8'hF1 → match_cnt=7, equal=0. A second start at T+3 with a=b=8'h00 is ignored: no extra done, and the result is still 7.
4. start held at 1 continuously with a=8'h0F, b=8'h3C → done pulses every 10 cycles; each done reports match_cnt=4, equal=0.
5. start a=b=8'hFF, then rst_n=0 for 1 cycle at T+4 → from T+5: busy=0, done=0, match_cnt=0, equal=0, and no done appears. A fresh start afterward completes normally with match_cnt=8.
6. Assert rst_n=0 and start=1 in the same cycle → state remains IDLE, busy=0 the next cycle.
